dmem_arbiter: RTL and testbench

//  Shares the single-port data_memory between two requesters: port 0 = CPU load/store

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 27 ++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
//   dmem_arb_state_t : transaction FSM state (IDLE -> ACCESS -> RESP)
//   port_idx_t       : index of a requesting port (0 = CPU LSU, 1 = boot loader)
//   N_PORTS          : number of requesters sharing the memory
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_arb_state_t;

  typedef logic port_idx_t;

  localparam int unsigned N_PORTS = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection (purely combinational).
//   eligible   in  [1:0]  ports currently allowed to win
//   last_grant in  1      port that completed the most recent transaction
//   valid      out 1      at least one port eligible
//   gnt        out 1      winning port, meaningful only when valid
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [N_PORTS-1:0] eligible,
  input  port_idx_t          last_grant,
  output logic               valid,
  output port_idx_t          gnt
);

  always_comb begin
    valid = |eligible;
    gnt   = 1'b0;
    unique case (eligible)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      // Contention: the port that did not go last wins, giving strict alternation.
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU load/store unit (port 0) and the
// boot/program loader (port 1). One transaction in flight, round-robin arbitration,
// req/ack handshake per port, three cycles from sampled request to ack.
//   CLK, reset          clock / asynchronous active-high reset
//   req, we             per-port request and write-enable, held until ack
//   addr0/1, wdata0/1   per-port address and write data
//   ack                 one-cycle completion pulse per port (at most one bit set)
//   rdata               data of the last completed read
//   mem_addr/wdata/we/re  drive the memory pins; mem_rdata returns with 1-cycle latency
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] we,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [DATA_W-1:0]  wdata0,
  input  logic [DATA_W-1:0]  wdata1,
  output logic [N_PORTS-1:0] ack,
  output logic [DATA_W-1:0]  rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [DATA_W-1:0]  mem_rdata
);

  dmem_arb_state_t state_q;
  port_idx_t       gnt_q;
  port_idx_t       last_grant_q;
  logic            we_q;

  logic [N_PORTS-1:0] eligible;
  logic               arb_valid;
  port_idx_t          arb_gnt;

  // A port being acked this cycle may still hold req; masking it stops a second service.
  assign eligible = req & ~ack;

  rr_arbiter2 u_rr_arbiter2 (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .gnt        (arb_gnt)
  );

  // mem_* are registered so the pins are glitch-free: they are loaded on the
  // IDLE->ACCESS edge and cleared on the ACCESS->RESP edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      ack          <= '0;
      rdata        <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
    end else begin
      ack <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_q     <= arb_gnt;
            we_q      <= we[arb_gnt];
            mem_addr  <= arb_gnt ? addr1 : addr0;
            mem_wdata <= arb_gnt ? wdata1 : wdata0;
            mem_we    <= we[arb_gnt];
            mem_re    <= ~we[arb_gnt];
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we  <= 1'b0;
          mem_re  <= 1'b0;
          state_q <= RESP;
        end
        RESP: begin
          // Memory read data is valid in this cycle.
          if (!we_q) rdata <= mem_rdata;
          ack[gnt_q]   <= 1'b1;
          last_grant_q <= gnt_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic [1:0]  req, we, ack;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int checks = 0;
  int errors = 0;

  // Memory behind the arbiter: synchronous write, registered read.
  logic [31:0] mem [256];
  logic        mem_init;

  // Reference model state.
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rdata;
  int          ref_last;

  dmem_arbiter dut (
    .CLK       (CLK),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Invariants checked every cycle.
  always @(negedge CLK) begin
    if (!mem_init) begin
      checks++;
      assert (!(mem_we && mem_re)) else begin
        errors++;
        $error("FAIL we_re_excl: observed we=%0b re=%0b expected not both", mem_we, mem_re);
      end
      checks++;
      assert (ack !== 2'b11) else begin
        errors++;
        $error("FAIL ack_onehot: observed %b expected at most one bit", ack);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  function automatic logic [1:0] onehot(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  // One uncontended transaction from idle; checks every cycle of the 3-cycle latency.
  task automatic single(input int p, input bit w, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] exp_rd;
    exp_rd = w ? exp_rdata : ref_mem[a];
    req[p] = 1'b1;
    we[p]  = w;
    if (p == 0) begin addr0 = 32'(a); wdata0 = d; end
    else        begin addr1 = 32'(a); wdata1 = d; end
    tick();
    chk("acc_we", mem_we, w);
    chk("acc_re", mem_re, !w);
    chk("acc_addr", mem_addr, 32'(a));
    if (w) chk("acc_wdata", mem_wdata, d);
    tick();
    chk("resp_we", mem_we, 0);
    chk("resp_re", mem_re, 0);
    chk("resp_ack", ack, 0);
    tick();
    chk("ack", ack, onehot(p));
    chk("rdata", rdata, exp_rd);
    req[p] = 1'b0;
    if (w) ref_mem[a] = d;
    exp_rdata = exp_rd;
    ref_last  = p;
    tick();
    chk("ack_pulse", ack, 0);
  endtask

  initial begin
    int p;
    int n;

    reset = 1'b1; mem_init = 1'b1;
    req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    exp_rdata = '0;
    ref_last  = 1;
    tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    mem_init = 1'b0;
    reset = 1'b0;
    tick();

    // Port 0 write then read back.
    single(0, 1'b1, 8'd3, 32'hDEAD_BEEF);
    single(0, 1'b0, 8'd3, 32'h0);

    // Reset while a write is in ACCESS: everything clears at once, no late ack.
    req[0] = 1'b1; we[0] = 1'b1; addr0 = 32'd9; wdata0 = 32'h0BAD_0BAD;
    tick();
    chk("mid_we", mem_we, 1);
    #1 reset = 1'b1;
    req = '0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_re", mem_re, 0);
    chk("mid_rst_rdata", rdata, 0);
    tick();
    reset = 1'b0;
    exp_rdata = '0;
    ref_last  = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dropped_ack", ack, 0);
    end

    // Simultaneous requests after reset: port 0 first, port 1 three cycles later.
    req = 2'b11; we = 2'b00; addr0 = 32'd1; addr1 = 32'd2;
    tick(); tick(); tick();
    chk("tie_ack0", ack, 2'b01);
    chk("tie_rd0", rdata, ref_mem[1]);
    req[0] = 1'b0;
    tick(); tick(); tick();
    chk("tie_ack1", ack, 2'b10);
    chk("tie_rd1", rdata, ref_mem[2]);
    req[1] = 1'b0;
    ref_last = 1;
    tick();
    chk("tie_idle", ack, 0);

    // Continuous contention: strict alternation, one ack every 3 cycles.
    req = 2'b11; we = 2'b00; addr0 = 32'd10; addr1 = 32'd11;
    p = 1 - ref_last;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin tick(); n++; end while (ack == 2'b00 && n < 10);
      chk("rr_ack", ack, onehot(p));
      chk("rr_gap", n, 3);
      chk("rr_rdata", rdata, ref_mem[(p == 0) ? 10 : 11]);
      if (k == 5) req = 2'b00;
      ref_last = p;
      p = 1 - p;
    end
    tick();
    chk("rr_idle", ack, 0);

    // Port 1 alone holds req one cycle past its ack: served once only.
    req[1] = 1'b1; we[1] = 1'b0; addr1 = 32'd4;
    tick(); tick(); tick();
    chk("hold_ack", ack, 2'b10);
    tick();
    req[1] = 1'b0;
    chk("hold_no_regrant", mem_re, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_no_ack", ack, 0);
    end

    // Port 1 holds past ack while port 0 arrives in the ack cycle: port 0 gets no gap.
    req[1] = 1'b1; we[1] = 1'b0; addr1 = 32'd5;
    tick(); tick(); tick();
    chk("ov_ack1", ack, 2'b10);
    chk("ov_rd1", rdata, ref_mem[5]);
    req[0] = 1'b1; we[0] = 1'b0; addr0 = 32'd6;
    tick();
    chk("ov_nogap_re", mem_re, 1);
    chk("ov_nogap_addr", mem_addr, 32'd6);
    req[1] = 1'b0;
    tick(); tick();
    chk("ov_ack0", ack, 2'b01);
    chk("ov_rd0", rdata, ref_mem[6]);
    req[0] = 1'b0;
    exp_rdata = ref_mem[6];
    ref_last  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ov_no_extra", ack, 0);
    end

    // Port 1 write: rdata keeps previous read value, mem_re low throughout.
    single(1, 1'b1, 8'd7, 32'h1234_5678);
    // The write aborted by reset must not have reached memory.
    single(0, 1'b0, 8'd9, 32'h0);
    single(1, 1'b0, 8'd7, 32'h0);

    // Randomized single transactions against the reference memory.
    for (int i = 0; i < 24; i++) begin
      single(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             8'($urandom_range(15, 0)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
